// File: rtl/datapath_regs_pkg.sv
// Shared encodings for the datapath register bank and the control FSM that drives it.
// Strobe bit positions apply equally to write_en, inc_en and clr_en.
package datapath_regs_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    localparam int SEL_PC     = 1;
    localparam int SEL_AR     = 2;
    localparam int SEL_IR     = 3;
    localparam int SEL_AC     = 4;
    localparam int SEL_R      = 5;
    localparam int SEL_R4     = 7;
    localparam int SEL_R3     = 8;
    localparam int SEL_R2     = 9;
    localparam int SEL_R1     = 10;
    localparam int SEL_DM     = 11;
    localparam int SEL_ALU_AC = 12;
    localparam int SEL_AC_R   = 13;

    typedef enum logic [3:0] {
        RD_NONE = 4'd0,
        RD_PC   = 4'd1,
        RD_AR   = 4'd2,
        RD_IR   = 4'd4,
        RD_AC   = 4'd5,
        RD_R    = 4'd6,
        RD_R1   = 4'd7,
        RD_R2   = 4'd8,
        RD_R3   = 4'd9,
        RD_R4   = 4'd10,
        RD_DM   = 4'd12,
        RD_IM   = 4'd13,
        RD_AC_R = 4'd14
    } rd_sel_e;

endpackage

// File: rtl/datapath_regs_if.sv
// Control, memory and ALU signals between the control side (master) and the register bank (slave).
interface datapath_regs_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [15:0]       write_en;
    logic [15:0]       inc_en;
    logic [15:0]       clr_en;
    logic [3:0]        read_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] dm_rdata;
    logic [DATA_W-1:0] im_rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        instruction;
    logic [15:0]       z;
    logic [DATA_W-1:0] bus_out;

    modport master (
        output write_en, inc_en, clr_en, read_en, alu_result, dm_rdata, im_rdata,
        input  dm_addr, dm_wdata, dm_we, im_addr, alu_a, alu_b, instruction, z, bus_out
    );

    modport slave (
        input  write_en, inc_en, clr_en, read_en, alu_result, dm_rdata, im_rdata,
        output dm_addr, dm_wdata, dm_we, im_addr, alu_a, alu_b, instruction, z, bus_out
    );
endinterface

// File: rtl/datapath_regs_dp_reg.sv
// One datapath register: async reset, then clear over load over increment on each rising edge.
module dp_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (load)
            q <= d;
        else if (inc)
            q <= q + DATA_W'(1);
    end

endmodule

// File: rtl/datapath_regs.sv
// Processor register bank: PC, AR, IR, AC, R, R1-R4 around a single shared bus.
// All sequencing comes from the control FSM; this block only applies the per-edge strobes.
module datapath_regs
    import datapath_regs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    datapath_regs_if.slave  io
);

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] pc, ar, ir, ac, r, r1, r2, r3, r4;
    logic [DATA_W-1:0] ac_d;
    logic              ac_load, r_load;

    always_comb begin
        bus = '0;
        case (rd_sel_e'(io.read_en))
            RD_PC:   bus = pc;
            RD_AR:   bus = ar;
            RD_IR:   bus = ir;
            RD_AC:   bus = ac;
            RD_R:    bus = r;
            RD_R1:   bus = r1;
            RD_R2:   bus = r2;
            RD_R3:   bus = r3;
            RD_R4:   bus = r4;
            RD_DM:   bus = io.dm_rdata;
            RD_IM:   bus = io.im_rdata;
            RD_AC_R: bus = ac;
            default: bus = '0;
        endcase
    end

    // AC has two load sources; the ALU result wins when both are strobed together.
    assign ac_load = io.write_en[SEL_AC] | io.write_en[SEL_ALU_AC];
    assign ac_d    = io.write_en[SEL_ALU_AC] ? io.alu_result : bus;
    assign r_load  = io.write_en[SEL_R] | io.write_en[SEL_AC_R];

    dp_reg #(.DATA_W(DATA_W)) u_pc (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_PC]),
        .load(io.write_en[SEL_PC]), .inc(io.inc_en[SEL_PC]), .d(bus), .q(pc));
    dp_reg #(.DATA_W(DATA_W)) u_ar (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_AR]),
        .load(io.write_en[SEL_AR]), .inc(io.inc_en[SEL_AR]), .d(bus), .q(ar));
    dp_reg #(.DATA_W(DATA_W)) u_ir (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_IR]),
        .load(io.write_en[SEL_IR]), .inc(io.inc_en[SEL_IR]), .d(bus), .q(ir));
    dp_reg #(.DATA_W(DATA_W)) u_ac (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_AC]),
        .load(ac_load), .inc(io.inc_en[SEL_AC]), .d(ac_d), .q(ac));
    dp_reg #(.DATA_W(DATA_W)) u_r  (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_R]),
        .load(r_load), .inc(io.inc_en[SEL_R]), .d(bus), .q(r));
    dp_reg #(.DATA_W(DATA_W)) u_r4 (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_R4]),
        .load(io.write_en[SEL_R4]), .inc(io.inc_en[SEL_R4]), .d(bus), .q(r4));
    dp_reg #(.DATA_W(DATA_W)) u_r3 (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_R3]),
        .load(io.write_en[SEL_R3]), .inc(io.inc_en[SEL_R3]), .d(bus), .q(r3));
    dp_reg #(.DATA_W(DATA_W)) u_r2 (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_R2]),
        .load(io.write_en[SEL_R2]), .inc(io.inc_en[SEL_R2]), .d(bus), .q(r2));
    dp_reg #(.DATA_W(DATA_W)) u_r1 (.clk(clk), .rst_n(rst_n), .clr(io.clr_en[SEL_R1]),
        .load(io.write_en[SEL_R1]), .inc(io.inc_en[SEL_R1]), .d(bus), .q(r1));

    // The memory write uses this cycle's AR and bus, so the store lands on the same edge.
    assign io.dm_addr     = ar[ADDR_W-1:0];
    assign io.dm_wdata    = bus;
    assign io.dm_we       = io.write_en[SEL_DM];
    assign io.im_addr     = pc[ADDR_W-1:0];
    assign io.alu_a       = ac;
    assign io.alu_b       = r;
    assign io.instruction = ir[4:0];
    assign io.z           = 16'(ac == '0);
    assign io.bus_out     = bus;

    logic unused_bits;
    assign unused_bits = ^{io.write_en[0], io.write_en[6], io.write_en[15:14],
                           io.inc_en[0], io.inc_en[6], io.inc_en[15:11],
                           io.clr_en[0], io.clr_en[6], io.clr_en[15:11],
                           ir[DATA_W-1:5]};

endmodule

// File: tb/tb_datapath_regs.sv
// Self-checking bench for datapath_regs: directed register-transfer scenarios, then random
// strobes compared every cycle against an array-based model of the register bank.
module tb_datapath_regs;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    datapath_regs_if #(.DATA_W(16), .ADDR_W(16)) dif ();

    datapath_regs dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state indexed by strobe bit: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1.
    logic [15:0] m  [0:15];
    logic [15:0] nm [0:15];
    int          reg_bits [9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};

    function automatic logic [15:0] model_bus();
        case (dif.read_en)
            4'd1:    return m[1];
            4'd2:    return m[2];
            4'd4:    return m[3];
            4'd5:    return m[4];
            4'd6:    return m[5];
            4'd7:    return m[10];
            4'd8:    return m[9];
            4'd9:    return m[8];
            4'd10:   return m[7];
            4'd12:   return dif.dm_rdata;
            4'd13:   return dif.im_rdata;
            4'd14:   return m[4];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 16; k++) m[k] = 16'h0000;
    endtask

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] b;
        b = model_bus();
        checkVal("bus_out", dif.bus_out, b);
        checkVal("dm_wdata", dif.dm_wdata, b);
        checkVal("dm_we", {15'h0, dif.dm_we}, {15'h0, dif.write_en[11]});
        checkVal("dm_addr", dif.dm_addr, m[2]);
        checkVal("im_addr", dif.im_addr, m[1]);
        checkVal("alu_a", dif.alu_a, m[4]);
        checkVal("alu_b", dif.alu_b, m[5]);
        checkVal("instruction", {11'h0, dif.instruction}, {11'h0, m[3][4:0]});
        checkVal("z", dif.z, (m[4] == 16'h0000) ? 16'h0001 : 16'h0000);
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic [15:0] inc, input logic [15:0] clr,
                                 input logic [3:0] rd, input logic [15:0] alu,
                                 input logic [15:0] dm, input logic [15:0] im);
        dif.write_en   = w;
        dif.inc_en     = inc;
        dif.clr_en     = clr;
        dif.read_en    = rd;
        dif.alu_result = alu;
        dif.dm_rdata   = dm;
        dif.im_rdata   = im;
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic tick();
        logic [15:0] b;
        int          k;
        logic        ld;
        logic [15:0] val;
        @(negedge clk);
        checkOutput();
        b = model_bus();
        for (int n = 0; n < 9; n++) begin
            k   = reg_bits[n];
            ld  = dif.write_en[k] || (k == 4 && dif.write_en[12]) || (k == 5 && dif.write_en[13]);
            val = (k == 4 && dif.write_en[12]) ? dif.alu_result : b;
            if (!rst_n)               nm[k] = 16'h0000;
            else if (dif.clr_en[k])   nm[k] = 16'h0000;
            else if (ld)              nm[k] = val;
            else if (dif.inc_en[k])   nm[k] = m[k] + 16'h0001;
            else                      nm[k] = m[k];
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 9; n++) m[reg_bits[n]] = nm[reg_bits[n]];
    endtask

    task automatic idle();
        applyStimulus(16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_zero();
        for (int k = 0; k < 16; k++) nm[k] = 16'h0000;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_z", dif.z, 16'h0001);
        checkVal("reset_instr", {11'h0, dif.instruction}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a cycle with AC holding a value
        applyStimulus(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h1234, 16'h0);
        tick();
        checkVal("ac_load_1234", dif.alu_a, 16'h1234);
        idle();
        #2;
        rst_n = 1'b0;
        model_zero();
        #1;
        checkVal("async_rst_ac", dif.alu_a, 16'h0000);
        checkVal("async_rst_z", dif.z, 16'h0001);
        applyStimulus(16'h0816, 16'h0002, 16'h0, 4'd12, 16'h0, 16'h5555, 16'h0);
        #1;
        checkVal("rst_dm_we", {15'h0, dif.dm_we}, 16'h0001);
        tick();
        checkVal("rst_strobe_ignored", dif.alu_a, 16'h0000);
        checkVal("rst_pc_held", dif.im_addr, 16'h0000);
        rst_n = 1'b1;
        idle();
        tick();

        // Fetch: IR from im_rdata, then PC increment
        applyStimulus(16'h0008, 16'h0, 16'h0, 4'd13, 16'h0, 16'h0, 16'h0013);
        tick();
        checkVal("fetch_instr", {11'h0, dif.instruction}, 16'h0013);
        applyStimulus(16'h0, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        tick();
        checkVal("fetch_pc_inc", dif.im_addr, 16'h0001);

        // Load/store through AR
        applyStimulus(16'h0004, 16'h0, 16'h0, 4'd12, 16'h0, 16'h0040, 16'h0);
        tick();
        applyStimulus(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h00AB, 16'h0);
        tick();
        checkVal("load_ac", dif.alu_a, 16'h00AB);
        applyStimulus(16'h0800, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
        #1;
        checkVal("store_we", {15'h0, dif.dm_we}, 16'h0001);
        checkVal("store_wdata", dif.dm_wdata, 16'h00AB);
        checkVal("store_addr", dif.dm_addr, 16'h0040);
        tick();

        // Move chain AC -> R1 -> AC
        applyStimulus(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'h0007, 16'h0);
        tick();
        applyStimulus(16'h0400, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0, 16'h0);
        tick();
        applyStimulus(16'h0, 16'h0, 16'h0010, 4'd7, 16'h0, 16'h0, 16'h0);
        #1;
        checkVal("r1_read", dif.bus_out, 16'h0007);
        tick();
        checkVal("clr_ac", dif.alu_a, 16'h0000);
        checkVal("clr_ac_z", dif.z, 16'h0001);
        applyStimulus(16'h0010, 16'h0, 16'h0, 4'd7, 16'h0, 16'h0, 16'h0);
        tick();
        checkVal("r1_to_ac", dif.alu_a, 16'h0007);
        checkVal("r1_to_ac_z", dif.z, 16'h0000);

        // AC conflicts: ALU beats bus, clear beats increment
        applyStimulus(16'h1010, 16'h0, 16'h0, 4'd12, 16'h0009, 16'h0005, 16'h0);
        tick();
        checkVal("alu_wins", dif.alu_a, 16'h0009);
        applyStimulus(16'h0, 16'h0010, 16'h0010, 4'd0, 16'h0, 16'h0, 16'h0);
        tick();
        checkVal("clr_over_inc", dif.alu_a, 16'h0000);

        // Wrap and unused read code
        applyStimulus(16'h0010, 16'h0, 16'h0, 4'd12, 16'h0, 16'hFFFF, 16'h0);
        tick();
        applyStimulus(16'h0, 16'h0010, 16'h0, 4'd0, 16'h0, 16'h0, 16'h0);
        tick();
        checkVal("wrap_ac", dif.alu_a, 16'h0000);
        checkVal("wrap_z", dif.z, 16'h0001);
        applyStimulus(16'h0, 16'h0, 16'h0, 4'd11, 16'h1111, 16'h2222, 16'h3333);
        #1;
        checkVal("unused_rd", dif.bus_out, 16'h0000);
        tick();

        // Random strobes with occasional mid-cycle reset
        for (int c = 0; c < 600; c++) begin
            rst_n = 1'b1;
            applyStimulus(16'($urandom & $urandom & $urandom),
                          16'($urandom & $urandom & $urandom),
                          16'($urandom & $urandom & $urandom & $urandom),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                          16'($urandom),
                          16'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst_n = 1'b0;
                model_zero();
            end
            tick();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
